// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer states, opcodes, ALU codes and
// the instruction classes produced by the opcode decoder.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_RTYPE,
        CL_IMM,
        CL_LD,
        CL_HALT
    } instr_class_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ROR  = 5'b01001;
    localparam logic [4:0] OP_ROL  = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_AND  = 5'b01100;
    localparam logic [4:0] ALU_OR   = 5'b01101;
    localparam logic [4:0] ALU_SHR  = 5'b00111;
    localparam logic [4:0] ALU_SHL  = 5'b01000;
    localparam logic [4:0] ALU_ROR  = 5'b01001;
    localparam logic [4:0] ALU_ROL  = 5'b01010;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: maps an opcode to its instruction class and
// the ALU operation it needs. Undefined opcodes behave as nop.
module op_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode_i,
    output instr_class_e cls_o,
    output logic [4:0]   alu_o
);

    always_comb begin
        cls_o = CL_NOP;
        alu_o = ALU_NONE;
        case (opcode_i)
            OP_LD:   begin cls_o = CL_LD;    alu_o = ALU_ADD; end
            OP_ADD:  begin cls_o = CL_RTYPE; alu_o = ALU_ADD; end
            OP_SUB:  begin cls_o = CL_RTYPE; alu_o = ALU_SUB; end
            OP_AND:  begin cls_o = CL_RTYPE; alu_o = ALU_AND; end
            OP_OR:   begin cls_o = CL_RTYPE; alu_o = ALU_OR;  end
            OP_SHR:  begin cls_o = CL_RTYPE; alu_o = ALU_SHR; end
            OP_SHL:  begin cls_o = CL_RTYPE; alu_o = ALU_SHL; end
            OP_ROR:  begin cls_o = CL_RTYPE; alu_o = ALU_ROR; end
            OP_ROL:  begin cls_o = CL_RTYPE; alu_o = ALU_ROL; end
            OP_ADDI: begin cls_o = CL_IMM;   alu_o = ALU_ADD; end
            OP_ANDI: begin cls_o = CL_IMM;   alu_o = ALU_AND; end
            OP_ORI:  begin cls_o = CL_IMM;   alu_o = ALU_OR;  end
            OP_HALT: begin cls_o = CL_HALT;  alu_o = ALU_NONE; end
            default: begin cls_o = CL_NOP;   alu_o = ALU_NONE; end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch in T0..T2, decode IR in T3, execute the
// remaining steps from the class and ALU code captured at the end of T3.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        ZLOout,
    output logic        MDRout,
    output logic        BAout,
    output logic        Cout,
    output logic        Rout,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Rin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncrementPC,
    output logic        Read,
    output logic [4:0]  ALUControl,
    output logic        Run
);

    state_e       state_q, state_d;
    instr_class_e cls_q, dec_cls;
    logic [4:0]   alu_q, dec_alu;

    // Register fields are steered by Gra/Grb/Grc in the datapath, not here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[26:0];

    op_decode u_op_decode (
        .opcode_i (IR[31:27]),
        .cls_o    (dec_cls),
        .alu_o    (dec_alu)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_RST;
            cls_q   <= CL_NOP;
            alu_q   <= ALU_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == S_T3) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        PCout       = 1'b0;
        ZLOout      = 1'b0;
        MDRout      = 1'b0;
        BAout       = 1'b0;
        Cout        = 1'b0;
        Rout        = 1'b0;
        PCin        = 1'b0;
        MARin       = 1'b0;
        MDRin       = 1'b0;
        IRin        = 1'b0;
        Yin         = 1'b0;
        Zin         = 1'b0;
        Rin         = 1'b0;
        Gra         = 1'b0;
        Grb         = 1'b0;
        Grc         = 1'b0;
        IncrementPC = 1'b0;
        Read        = 1'b0;
        ALUControl  = ALU_NONE;
        Run         = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_RST: state_d = S_T0;
            S_T0: begin
                if (!Stop) begin
                    PCout       = 1'b1;
                    MARin       = 1'b1;
                    IncrementPC = 1'b1;
                    Zin         = 1'b1;
                    state_d     = S_T1;
                end
            end
            S_T1: begin
                ZLOout  = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            // T3 decodes the live IR; later steps use only the captured copy.
            S_T3: begin
                case (dec_cls)
                    CL_RTYPE, CL_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_d = S_T4;
                    end
                    CL_LD: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_d = S_T4;
                    end
                    CL_HALT: state_d = S_HALT;
                    default: state_d = S_T0;
                endcase
            end
            S_T4: begin
                Zin        = 1'b1;
                ALUControl = alu_q;
                if (cls_q == CL_RTYPE) begin
                    Grc  = 1'b1;
                    Rout = 1'b1;
                end else begin
                    Cout = 1'b1;
                end
                state_d = S_T5;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (cls_q == CL_LD) begin
                    MARin   = 1'b1;
                    state_d = S_T6;
                end else begin
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T6: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T7;
            end
            S_T7: begin
                MDRout  = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                state_d = S_T0;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes the
// expected output word, a negedge monitor pops and compares it.
module tb_control_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, ZLOout, MDRout, BAout, Cout, Rout;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin;
    logic        Gra, Grb, Grc, IncrementPC, Read, Run;
    logic [4:0]  ALUControl;

    always #5 Clock = ~Clock;

    control_sequencer dut (
        .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Stop(Stop),
        .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .BAout(BAout),
        .Cout(Cout), .Rout(Rout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Rin(Rin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .IncrementPC(IncrementPC), .Read(Read),
        .ALUControl(ALUControl), .Run(Run)
    );

    localparam logic [23:0] O_PCOUT  = 24'd1 << 0;
    localparam logic [23:0] O_ZLOOUT = 24'd1 << 1;
    localparam logic [23:0] O_MDROUT = 24'd1 << 2;
    localparam logic [23:0] O_BAOUT  = 24'd1 << 3;
    localparam logic [23:0] O_COUT   = 24'd1 << 4;
    localparam logic [23:0] O_ROUT   = 24'd1 << 5;
    localparam logic [23:0] O_PCIN   = 24'd1 << 6;
    localparam logic [23:0] O_MARIN  = 24'd1 << 7;
    localparam logic [23:0] O_MDRIN  = 24'd1 << 8;
    localparam logic [23:0] O_IRIN   = 24'd1 << 9;
    localparam logic [23:0] O_YIN    = 24'd1 << 10;
    localparam logic [23:0] O_ZIN    = 24'd1 << 11;
    localparam logic [23:0] O_RIN    = 24'd1 << 12;
    localparam logic [23:0] O_GRA    = 24'd1 << 13;
    localparam logic [23:0] O_GRB    = 24'd1 << 14;
    localparam logic [23:0] O_GRC    = 24'd1 << 15;
    localparam logic [23:0] O_INCPC  = 24'd1 << 16;
    localparam logic [23:0] O_READ   = 24'd1 << 17;
    localparam logic [23:0] O_RUN    = 24'd1 << 23;

    function automatic logic [23:0] alu_f(input logic [4:0] code);
        return {1'b0, code, 18'd0};
    endfunction

    logic [23:0] obs_vec;
    assign obs_vec = {Run, ALUControl, Read, IncrementPC, Grc, Grb, Gra, Rin,
                      Zin, Yin, IRin, MDRin, MARin, PCin, Rout, Cout, BAout,
                      MDRout, ZLOout, PCout};

    logic [23:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check_eq(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            logic [23:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, obs_vec, e);
        end
    end

    // One clock cycle: apply inputs, record what this state must drive, advance.
    task automatic step(input string tag, input logic rstn, input logic stp,
                        input logic [31:0] ir, input logic [23:0] exp);
        Reset_n = rstn;
        Stop    = stp;
        IR      = ir;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input string name, input logic [31:0] ir);
        step({name, ".T0"}, 1'b1, 1'b0, 32'hFFFF_FFFF, O_PCOUT | O_MARIN | O_INCPC | O_ZIN | O_RUN);
        step({name, ".T1"}, 1'b1, 1'b0, 32'hFFFF_FFFF, O_ZLOOUT | O_PCIN | O_READ | O_MDRIN | O_RUN);
        step({name, ".T2"}, 1'b1, 1'b0, ir, O_MDROUT | O_IRIN | O_RUN);
    endtask

    // IR is scrambled after T3 to show the captured decode is what executes.
    task automatic run_rtype(input string name, input logic [31:0] ir, input logic [4:0] alu);
        fetch(name, ir);
        step({name, ".T3"}, 1'b1, 1'b0, ir, O_GRB | O_ROUT | O_YIN | O_RUN);
        step({name, ".T4"}, 1'b1, 1'b1, 32'hD800_0000, O_GRC | O_ROUT | alu_f(alu) | O_ZIN | O_RUN);
        step({name, ".T5"}, 1'b1, 1'b1, 32'h0000_0000, O_ZLOOUT | O_GRA | O_RIN | O_RUN);
    endtask

    task automatic run_imm(input string name, input logic [31:0] ir, input logic [4:0] alu);
        fetch(name, ir);
        step({name, ".T3"}, 1'b1, 1'b0, ir, O_GRB | O_ROUT | O_YIN | O_RUN);
        step({name, ".T4"}, 1'b1, 1'b0, 32'h2891_8000, O_COUT | alu_f(alu) | O_ZIN | O_RUN);
        step({name, ".T5"}, 1'b1, 1'b0, ir, O_ZLOOUT | O_GRA | O_RIN | O_RUN);
    endtask

    task automatic run_ld_to_t5(input string name, input logic [31:0] ir);
        fetch(name, ir);
        step({name, ".T3"}, 1'b1, 1'b0, ir, O_GRB | O_BAOUT | O_YIN | O_RUN);
        step({name, ".T4"}, 1'b1, 1'b0, 32'h5000_0000, O_COUT | alu_f(5'b00011) | O_ZIN | O_RUN);
        step({name, ".T5"}, 1'b1, 1'b0, ir, O_ZLOOUT | O_MARIN | O_RUN);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n = 1'b0;
        Stop    = 1'b0;
        IR      = 32'h0;
        @(posedge Clock);
        #1;
        step("rst.hold", 1'b0, 1'b0, 32'h0, 24'd0);
        step("rst.release", 1'b1, 1'b0, 32'h0, 24'd0);

        run_rtype("and", 32'h2891_8000, 5'b01100);
        run_rtype("sub", 32'h2091_8000, 5'b00100);
        run_rtype("shl", 32'h4091_8000, 5'b01000);
        run_rtype("rol", 32'h5091_8000, 5'b01010);
        run_imm("addi", 32'h6088_0005, 5'b00011);
        run_imm("ori", 32'h7088_0005, 5'b01101);

        run_ld_to_t5("ld", 32'h0088_0010);
        step("ld.T6", 1'b1, 1'b0, 32'h0, O_READ | O_MDRIN | O_RUN);
        step("ld.T7", 1'b1, 1'b0, 32'h0, O_MDROUT | O_GRA | O_RIN | O_RUN);

        // Reset asserted in T6: T6 still drives, then RST is all zero.
        run_ld_to_t5("ldrst", 32'h0088_0010);
        step("ldrst.T6", 1'b0, 1'b0, 32'h0, O_READ | O_MDRIN | O_RUN);
        step("ldrst.RST", 1'b1, 1'b0, 32'h0, 24'd0);

        for (int i = 0; i < 3; i++)
            step($sformatf("stop.%0d", i), 1'b1, 1'b1, 32'h0, O_RUN);
        fetch("nop", 32'hD000_0000);
        step("nop.T3", 1'b1, 1'b0, 32'hD000_0000, O_RUN);
        fetch("undef", 32'hF800_0000);
        step("undef.T3", 1'b1, 1'b0, 32'hF800_0000, O_RUN);

        fetch("halt", 32'hD800_0000);
        step("halt.T3", 1'b1, 1'b0, 32'hD800_0000, O_RUN);
        for (int i = 0; i < 20; i++)
            step($sformatf("halt.hold%0d", i), 1'b1, 1'($urandom_range(1)), $urandom, 24'd0);
        step("halt.rst", 1'b0, 1'b0, 32'h0, 24'd0);
        step("halt.RST", 1'b1, 1'b0, 32'h0, 24'd0);
        run_rtype("post", 32'h1891_8000, 5'b00011);

        @(negedge Clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
